// File: rtl/sdram_ch1_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : sdram_ch1_arbiter_if
// Brief    : Client request/response and SDRAM ch1 command bundle for the arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface sdram_ch1_arbiter_if #(
    parameter int NREQ   = 3,
    parameter int ADDR_W = 27
);
    logic [NREQ-1:0]        req_ena;
    logic [NREQ-1:0]        req_rnw;
    logic [NREQ*ADDR_W-1:0] req_adr;
    logic [NREQ*4-1:0]      req_be;
    logic [NREQ*32-1:0]     req_wdata;
    logic [NREQ-1:0]        req_done;
    logic [31:0]            req_rdata;
    logic                   sdram_ena;
    logic                   sdram_rnw;
    logic [ADDR_W-1:0]      sdram_Adr;
    logic [3:0]             sdram_be;
    logic [31:0]            sdram_dataWrite;
    logic                   sdram_done;
    logic [31:0]            sdram_dataRead;
    logic                   err_overrun;
    logic                   err_timeout;

    // Clients plus the SDRAM channel model drive this side.
    modport master (
        output req_ena, req_rnw, req_adr, req_be, req_wdata,
        output sdram_done, sdram_dataRead,
        input  req_done, req_rdata,
        input  sdram_ena, sdram_rnw, sdram_Adr, sdram_be, sdram_dataWrite,
        input  err_overrun, err_timeout
    );

    modport slave (
        input  req_ena, req_rnw, req_adr, req_be, req_wdata,
        input  sdram_done, sdram_dataRead,
        output req_done, req_rdata,
        output sdram_ena, sdram_rnw, sdram_Adr, sdram_be, sdram_dataWrite,
        output err_overrun, err_timeout
    );
endinterface
`default_nettype wire

// File: rtl/sdram_ch1_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sdram_ch1_arbiter
// Brief    : Round-robin arbiter sharing SDRAM ch1 between NREQ latched clients.
// Revision : 1.0 - initial release
// ============================================================================
module sdram_ch1_arbiter #(
    parameter int NREQ    = 3,
    parameter int ADDR_W  = 27,
    parameter int TIMEOUT = 1024
) (
    input  wire logic            clk1x,
    input  wire logic            reset,
    sdram_ch1_arbiter_if.slave   bus
);
    localparam int c_idx_w = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int c_cnt_w = $clog2(TIMEOUT);
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(TIMEOUT - 1);
    localparam logic [c_idx_w-1:0] c_last    = c_idx_w'(NREQ - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t               r_state;
    logic [NREQ-1:0]      r_pending;
    logic [c_idx_w-1:0]   r_rr;
    logic [c_idx_w-1:0]   r_gnt;
    logic [c_cnt_w-1:0]   r_cnt;

    logic                 r_slot_rnw   [NREQ];
    logic [ADDR_W-1:0]    r_slot_adr   [NREQ];
    logic [3:0]           r_slot_be    [NREQ];
    logic [31:0]          r_slot_wdata [NREQ];

    logic                 r_sdram_ena;
    logic                 r_sdram_rnw;
    logic [ADDR_W-1:0]    r_sdram_adr;
    logic [3:0]           r_sdram_be;
    logic [31:0]          r_sdram_wdata;
    logic [NREQ-1:0]      r_req_done;
    logic [31:0]          r_req_rdata;
    logic                 r_err_overrun;
    logic                 r_err_timeout;

    logic                 w_found;
    logic [c_idx_w-1:0]   w_sel;
    logic [c_idx_w:0]     w_idx;
    logic                 w_complete;

    // First pending client scanning rr, rr+1, ... wrapping at NREQ.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = {1'b0, r_rr} + (c_idx_w + 1)'(k);
            if (w_idx >= (c_idx_w + 1)'(NREQ)) begin
                w_idx = w_idx - (c_idx_w + 1)'(NREQ);
            end
            if (!w_found && r_pending[w_idx[c_idx_w-1:0]]) begin
                w_found = 1'b1;
                w_sel   = w_idx[c_idx_w-1:0];
            end
        end
    end

    assign w_complete = bus.sdram_done || (r_cnt == c_cnt_max);

    always_ff @(posedge clk1x or posedge reset) begin
        if (reset) begin
            r_state       <= IDLE;
            r_pending     <= '0;
            r_rr          <= '0;
            r_gnt         <= '0;
            r_cnt         <= '0;
            r_sdram_ena   <= 1'b0;
            r_sdram_rnw   <= 1'b0;
            r_sdram_adr   <= '0;
            r_sdram_be    <= '0;
            r_sdram_wdata <= '0;
            r_req_done    <= '0;
            r_req_rdata   <= '0;
            r_err_overrun <= 1'b0;
            r_err_timeout <= 1'b0;
            for (int i = 0; i < NREQ; i++) begin
                r_slot_rnw[i]   <= 1'b0;
                r_slot_adr[i]   <= '0;
                r_slot_be[i]    <= '0;
                r_slot_wdata[i] <= '0;
            end
        end else begin
            r_sdram_ena <= 1'b0;
            r_req_done  <= '0;

            // A completing client still reads as pending here, so a pulse on it is an overrun.
            for (int i = 0; i < NREQ; i++) begin
                if (bus.req_ena[i]) begin
                    if (r_pending[i]) begin
                        r_err_overrun <= 1'b1;
                    end else begin
                        r_pending[i]    <= 1'b1;
                        r_slot_rnw[i]   <= bus.req_rnw[i];
                        r_slot_adr[i]   <= bus.req_adr[i*ADDR_W +: ADDR_W];
                        r_slot_be[i]    <= bus.req_be[i*4 +: 4];
                        r_slot_wdata[i] <= bus.req_wdata[i*32 +: 32];
                    end
                end
            end

            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_gnt         <= w_sel;
                        r_sdram_ena   <= 1'b1;
                        r_sdram_rnw   <= r_slot_rnw[w_sel];
                        r_sdram_adr   <= r_slot_adr[w_sel];
                        r_sdram_be    <= r_slot_be[w_sel];
                        r_sdram_wdata <= r_slot_wdata[w_sel];
                        r_cnt         <= '0;
                        r_state       <= WAIT;
                    end
                end
                WAIT: begin
                    if (w_complete) begin
                        r_req_done[r_gnt] <= 1'b1;
                        r_req_rdata       <= bus.sdram_done ? bus.sdram_dataRead : 32'd0;
                        if (!bus.sdram_done) begin
                            r_err_timeout <= 1'b1;
                        end
                        r_pending[r_gnt] <= 1'b0;
                        r_rr             <= (r_gnt == c_last) ? '0 : r_gnt + 1'b1;
                        r_state          <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.sdram_ena       = r_sdram_ena;
    assign bus.sdram_rnw       = r_sdram_rnw;
    assign bus.sdram_Adr       = r_sdram_adr;
    assign bus.sdram_be        = r_sdram_be;
    assign bus.sdram_dataWrite = r_sdram_wdata;
    assign bus.req_done        = r_req_done;
    assign bus.req_rdata       = r_req_rdata;
    assign bus.err_overrun     = r_err_overrun;
    assign bus.err_timeout     = r_err_timeout;

endmodule
`default_nettype wire

// File: tb/tb_sdram_ch1_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sdram_ch1_arbiter
// Brief    : Directed self-checking bench for sdram_ch1_arbiter (NREQ=3, TIMEOUT=16).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sdram_ch1_arbiter;
    localparam int NREQ    = 3;
    localparam int ADDR_W  = 27;
    localparam int TIMEOUT = 16;

    logic clk1x = 1'b0;
    logic reset = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    sdram_ch1_arbiter_if #(.NREQ(NREQ), .ADDR_W(ADDR_W)) bus ();

    sdram_ch1_arbiter #(.NREQ(NREQ), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk1x (clk1x),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk1x = ~clk1x;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic step();
        @(posedge clk1x);
        #1;
    endtask

    task automatic set_slot(input int i, input logic rnw, input logic [ADDR_W-1:0] adr,
                            input logic [3:0] be, input logic [31:0] wd);
        bus.req_rnw[i]                    = rnw;
        bus.req_adr[i*ADDR_W +: ADDR_W]   = adr;
        bus.req_be[i*4 +: 4]              = be;
        bus.req_wdata[i*32 +: 32]         = wd;
    endtask

    task automatic pulse(input logic [NREQ-1:0] ena);
        bus.req_ena = ena;
        step();
        bus.req_ena = '0;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        bus.req_ena = '0;
        bus.sdram_done = 1'b0;
        bus.sdram_dataRead = '0;
        step();
        step();
        reset = 1'b0;
        step();
    endtask

    // Waits (bounded) for a command, answers it after lat cycles, returns what was seen.
    task automatic serve(input int lat, input logic [31:0] data, output logic got,
                         output logic [ADDR_W-1:0] adr, output logic rnw, output logic [3:0] be,
                         output logic [31:0] wd, output logic [NREQ-1:0] dn, output logic [31:0] rd);
        got = 1'b0; adr = '0; rnw = 1'b0; be = '0; wd = '0; dn = '0; rd = '0;
        for (int t = 0; t < 40 && !got; t++) begin
            if (bus.sdram_ena) got = 1'b1;
            else step();
        end
        if (got) begin
            adr = bus.sdram_Adr; rnw = bus.sdram_rnw; be = bus.sdram_be; wd = bus.sdram_dataWrite;
            for (int k = 0; k < lat; k++) step();
            bus.sdram_done = 1'b1;
            bus.sdram_dataRead = data;
            step();
            bus.sdram_done = 1'b0;
            bus.sdram_dataRead = '0;
            dn = bus.req_done;
            rd = bus.req_rdata;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1;
        n_checks++;
        if ({bus.sdram_ena, bus.sdram_rnw, bus.sdram_Adr, bus.sdram_be, bus.sdram_dataWrite,
             bus.req_done, bus.req_rdata, bus.err_overrun, bus.err_timeout} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got ena=%b adr=%h done=%b rdata=%h errs=%b%b required all zero",
                     bus.sdram_ena, bus.sdram_Adr, bus.req_done, bus.req_rdata, bus.err_overrun, bus.err_timeout);
        end
        apply_reset();
    endtask

    task automatic test_single_read();
        set_slot(1, 1'b1, 27'h0100000, 4'hF, 32'h0);
        pulse(3'b010);
        n_checks++;
        if (bus.sdram_ena !== 1'b0) begin n_fail++; $display("FAIL read_ena_early: got %b required 0", bus.sdram_ena); end
        step();
        n_checks++;
        if (bus.sdram_ena !== 1'b1 || bus.sdram_Adr !== 27'h0100000 || bus.sdram_rnw !== 1'b1) begin
            n_fail++;
            $display("FAIL read_issue: got ena=%b adr=%h rnw=%b required 1 0100000 1", bus.sdram_ena, bus.sdram_Adr, bus.sdram_rnw);
        end
        step();
        n_checks++;
        if (bus.sdram_ena !== 1'b0) begin n_fail++; $display("FAIL read_ena_single: got %b required 0", bus.sdram_ena); end
        bus.sdram_done = 1'b1; bus.sdram_dataRead = 32'hDEADBEEF;
        step();
        bus.sdram_done = 1'b0; bus.sdram_dataRead = '0;
        n_checks++;
        if (bus.req_done !== 3'b010 || bus.req_rdata !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL read_done: got done=%b rdata=%h required 010 deadbeef", bus.req_done, bus.req_rdata);
        end
        step();
        n_checks++;
        if (bus.req_done !== 3'b000 || bus.req_rdata !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL read_hold: got done=%b rdata=%h required 000 deadbeef", bus.req_done, bus.req_rdata);
        end
    endtask

    // A new pulse in the req_done cycle of the same client must be captured.
    task automatic test_back_to_back();
        logic got; logic [ADDR_W-1:0] adr; logic rnw; logic [3:0] be; logic [31:0] wd, rd; logic [NREQ-1:0] dn;
        set_slot(0, 1'b1, 27'h0000A00, 4'hF, 32'h0);
        pulse(3'b001);
        serve(1, 32'h11111111, got, adr, rnw, be, wd, dn, rd);
        n_checks++;
        if (!got || adr !== 27'h0000A00 || dn !== 3'b001 || rd !== 32'h11111111) begin
            n_fail++;
            $display("FAIL b2b_first: got ena=%b adr=%h done=%b rdata=%h required 1 0000a00 001 11111111", got, adr, dn, rd);
        end
        set_slot(0, 1'b1, 27'h0000B00, 4'hF, 32'h0);
        pulse(3'b001);
        serve(0, 32'h22222222, got, adr, rnw, be, wd, dn, rd);
        n_checks++;
        if (!got || adr !== 27'h0000B00 || dn !== 3'b001 || rd !== 32'h22222222) begin
            n_fail++;
            $display("FAIL b2b_second: got ena=%b adr=%h done=%b rdata=%h required 1 0000b00 001 22222222", got, adr, dn, rd);
        end
    endtask

    task automatic test_round_robin();
        logic got; logic [ADDR_W-1:0] adr; logic rnw; logic [3:0] be; logic [31:0] wd, rd; logic [NREQ-1:0] dn;
        logic [1:0] exp_order [7];
        exp_order = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd2};
        apply_reset();
        for (int i = 0; i < NREQ; i++) set_slot(i, 1'b1, 27'(32'h10 * (i + 1)), 4'hF, 32'h0);
        for (int b = 0; b < 2; b++) begin
            pulse(3'b111);
            for (int s = 0; s < 3; s++) begin
                int e;
                e = exp_order[b*3+s];
                serve(4, 32'hC000_0000 + 32'(s), got, adr, rnw, be, wd, dn, rd);
                n_checks++;
                if (!got || adr !== 27'(32'h10 * (e + 1)) || dn !== 3'(1 << e)) begin
                    n_fail++;
                    $display("FAIL rr_burst%0d_slot%0d: got ena=%b adr=%h done=%b required client %0d", b, s, got, adr, dn, e);
                end
            end
        end
        pulse(3'b100);
        serve(4, 32'h0, got, adr, rnw, be, wd, dn, rd);
        n_checks++;
        if (!got || dn !== 3'b100) begin n_fail++; $display("FAIL rr_single2: got ena=%b done=%b required 1 100", got, dn); end
        pulse(3'b101);
        serve(4, 32'h0, got, adr, rnw, be, wd, dn, rd);
        n_checks++;
        if (!got || dn !== 3'b001 || adr !== 27'h10) begin n_fail++; $display("FAIL rr_pair_first: got done=%b adr=%h required 001 0000010", dn, adr); end
        serve(4, 32'h0, got, adr, rnw, be, wd, dn, rd);
        n_checks++;
        if (!got || dn !== 3'b100 || adr !== 27'h30) begin n_fail++; $display("FAIL rr_pair_second: got done=%b adr=%h required 100 0000030", dn, adr); end
    endtask

    task automatic test_write();
        logic got; logic [ADDR_W-1:0] adr; logic rnw; logic [3:0] be; logic [31:0] wd, rd; logic [NREQ-1:0] dn;
        set_slot(2, 1'b0, 27'h0200040, 4'b0011, 32'h12345678);
        pulse(3'b100);
        serve(3, 32'h0, got, adr, rnw, be, wd, dn, rd);
        n_checks++;
        if (!got || rnw !== 1'b0 || be !== 4'b0011 || wd !== 32'h12345678 || adr !== 27'h0200040) begin
            n_fail++;
            $display("FAIL write_cmd: got ena=%b rnw=%b be=%b wd=%h adr=%h required 1 0 0011 12345678 0200040", got, rnw, be, wd, adr);
        end
        n_checks++;
        if (dn !== 3'b100) begin n_fail++; $display("FAIL write_done: got %b required 100", dn); end
    endtask

    task automatic test_overrun();
        logic got; logic [ADDR_W-1:0] adr; logic rnw; logic [3:0] be; logic [31:0] wd, rd; logic [NREQ-1:0] dn;
        int extra;
        apply_reset();
        n_checks++;
        if (bus.err_overrun !== 1'b0) begin n_fail++; $display("FAIL overrun_clear: got %b required 0", bus.err_overrun); end
        set_slot(0, 1'b1, 27'h0000080, 4'hF, 32'h0);
        pulse(3'b001);
        set_slot(0, 1'b1, 27'h0000090, 4'hF, 32'h0);
        pulse(3'b001);
        n_checks++;
        if (bus.err_overrun !== 1'b1) begin n_fail++; $display("FAIL overrun_flag: got %b required 1", bus.err_overrun); end
        serve(2, 32'h0, got, adr, rnw, be, wd, dn, rd);
        n_checks++;
        if (!got || adr !== 27'h0000080 || dn !== 3'b001) begin
            n_fail++;
            $display("FAIL overrun_addr: got ena=%b adr=%h done=%b required 1 0000080 001", got, adr, dn);
        end
        extra = 0;
        for (int t = 0; t < 10; t++) begin step(); if (bus.sdram_ena) extra++; end
        n_checks++;
        if (extra !== 0 || bus.err_overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL overrun_extra: got %0d extra issues, flag=%b required 0 and 1", extra, bus.err_overrun);
        end
    endtask

    task automatic test_timeout();
        logic got; logic [ADDR_W-1:0] adr; logic rnw; logic [3:0] be; logic [31:0] wd, rd; logic [NREQ-1:0] dn;
        int early;
        apply_reset();
        set_slot(0, 1'b1, 27'h0000040, 4'hF, 32'h0);
        set_slot(1, 1'b1, 27'h0000050, 4'hF, 32'h0);
        bus.sdram_dataRead = 32'hFFFFFFFF;
        pulse(3'b011);
        step();
        n_checks++;
        if (bus.sdram_ena !== 1'b1 || bus.sdram_Adr !== 27'h0000040) begin
            n_fail++;
            $display("FAIL to_issue: got ena=%b adr=%h required 1 0000040", bus.sdram_ena, bus.sdram_Adr);
        end
        early = 0;
        for (int t = 1; t < TIMEOUT; t++) begin step(); if (bus.req_done !== 3'b000) early++; end
        n_checks++;
        if (early !== 0 || bus.err_timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL to_early: got %0d early done cycles, flag=%b required 0 and 0", early, bus.err_timeout);
        end
        step();
        n_checks++;
        if (bus.req_done !== 3'b001 || bus.req_rdata !== 32'h0 || bus.err_timeout !== 1'b1) begin
            n_fail++;
            $display("FAIL to_done: got done=%b rdata=%h flag=%b required 001 00000000 1", bus.req_done, bus.req_rdata, bus.err_timeout);
        end
        step();
        n_checks++;
        if (bus.sdram_ena !== 1'b1 || bus.sdram_Adr !== 27'h0000050) begin
            n_fail++;
            $display("FAIL to_next_issue: got ena=%b adr=%h required 1 0000050", bus.sdram_ena, bus.sdram_Adr);
        end
        bus.sdram_dataRead = '0;
        serve(2, 32'h5A5A5A5A, got, adr, rnw, be, wd, dn, rd);
        n_checks++;
        if (!got || dn !== 3'b010 || rd !== 32'h5A5A5A5A) begin
            n_fail++;
            $display("FAIL to_after: got ena=%b done=%b rdata=%h required 1 010 5a5a5a5a", got, dn, rd);
        end
    endtask

    task automatic test_reset_mid_op();
        logic got; logic [ADDR_W-1:0] adr; logic rnw; logic [3:0] be; logic [31:0] wd, rd; logic [NREQ-1:0] dn;
        set_slot(1, 1'b1, 27'h0000060, 4'hF, 32'h0);
        pulse(3'b010);
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        bus.sdram_done = 1'b1; bus.sdram_dataRead = 32'hAAAA5555;
        step();
        bus.sdram_done = 1'b0; bus.sdram_dataRead = '0;
        n_checks++;
        if (bus.req_done !== 3'b000 || bus.req_rdata !== 32'h0 || bus.sdram_ena !== 1'b0 ||
            bus.sdram_Adr !== '0 || bus.err_timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_stale: got done=%b rdata=%h ena=%b adr=%h to=%b required all zero",
                     bus.req_done, bus.req_rdata, bus.sdram_ena, bus.sdram_Adr, bus.err_timeout);
        end
        step();
        n_checks++;
        if (bus.req_done !== 3'b000 || bus.sdram_ena !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_quiet: got done=%b ena=%b required 000 0", bus.req_done, bus.sdram_ena);
        end
        set_slot(2, 1'b1, 27'h0000070, 4'hF, 32'h0);
        pulse(3'b100);
        serve(2, 32'h0BADF00D, got, adr, rnw, be, wd, dn, rd);
        n_checks++;
        if (!got || adr !== 27'h0000070 || dn !== 3'b100 || rd !== 32'h0BADF00D) begin
            n_fail++;
            $display("FAIL rst_fresh: got ena=%b adr=%h done=%b rdata=%h required 1 0000070 100 0badf00d", got, adr, dn, rd);
        end
    endtask

    initial begin
        bus.req_ena = '0; bus.req_rnw = '0; bus.req_adr = '0; bus.req_be = '0; bus.req_wdata = '0;
        bus.sdram_done = 1'b0; bus.sdram_dataRead = '0;
        test_reset();
        test_single_read();
        test_back_to_back();
        test_round_robin();
        test_write();
        test_overrun();
        test_timeout();
        test_reset_mid_op();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
